matrix_frame_writer: RTL and testbench
======================================

Name: matrix_frame_writer

Overview:
Converts the host byte stream into pixel writes for the LED matrix driver. It sits between the byte receiver (UART/SPI) and the matrix output stage. It parses framed packets (sync, start address, length, payload) and emits one address/data write strobe per payload byte. Addresses auto-increment and wrap within the LED value memory.

Parameters:
BOARDS, 3, number of driver boards in chain
ROWS, 4, scan rows per board
ADDR_W, 9, width of address_out
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 100000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
byte_in  input  8  received byte
byte_valid_in  input  1  one-cycle strobe, byte_in valid
address_out  output  ADDR_W  LED memory address
data_out  output  8  8-bit brightness value
write_strobe_out  output  1  one-cycle write strobe
frame_done  output  1  one-cycle pulse after last payload byte written
frame_error  output  1  one-cycle pulse on rejected/aborted frame
busy  output  1  high while not in IDLE

Behaviour:
- Reset is synchronous, active-high, on clock clk (rst high). Outputs reset to 0. State resets to IDLE.
- TOTAL = BOARDS*16*ROWS (default 192). Its width must fit in ADDR_W; a mismatch is an elaboration error.
- Frame format: SYNC_BYTE, ADDR_H (only bit0 used = addr[8], bits 7:1 ignored), ADDR_L, LEN (payload count minus 1, so 1..256 bytes), then LEN+1 payload bytes.
- State transitions, each taken on byte_valid_in:
  - IDLE: on SYNC_BYTE go to GET_AH. Any other byte is ignored, with no error.
  - GET_AH: latch addr[8], go to GET_AL.
  - GET_AL: latch addr[7:0], go to GET_LEN.
  - GET_LEN: latch remaining count = LEN.
    - If start addr < TOTAL, go to DATA.
    - Otherwise go to DISCARD and pulse frame_error.
  - DATA, per byte:
    - address_out = current addr, data_out = byte_in, write_strobe_out = 1 for exactly one cycle.
    - Latency is 1 cycle from byte_valid_in (outputs registered).
    - Then addr = (addr == TOTAL-1) ? 0 : addr+1, and the count decrements.
    - When the count was 0, pulse frame_done in the same cycle as the final strobe and go to IDLE.
  - DISCARD: consume LEN+1 bytes with no strobe, then go to IDLE. No frame_done.
- SYNC_BYTE received inside DATA or DISCARD is treated as data, with no resync.
- address_out and data_out hold their last values between strobes. write_strobe_out is 0 when byte_valid_in is low.
- Back-to-back byte_valid_in on consecutive cycles must be accepted without loss.
- Reset mid-frame: state returns to IDLE, no strobe in the reset cycle, and the partial frame is dropped with no frame_error.
- busy = (state != IDLE).

Optional Feature:
MATRIX_FRAME_TIMEOUT_EN
- Defined:
  - A counter clears on every byte_valid_in and whenever in IDLE, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 outside IDLE: go to IDLE and pulse frame_error. Writes already issued are not undone.
  - If byte_valid_in coincides with the timeout cycle, the byte wins: it is processed and the counter clears.
- Undefined: no counter and no timeout. A truncated frame waits indefinitely for more bytes.

Decomposition:
- Shared package matrix_pkg holds:
  - OUTPUTS_PER_BOARD = 16 and SYNC_BYTE default.
  - State enum {IDLE, GET_AH, GET_AL, GET_LEN, DATA, DISCARD}.
  - A TOTAL-outputs function of BOARDS and ROWS, also used by the matrix output stage.
- No sub-module. The timeout counter is inline; the byte receiver is a separate existing block.

Test Plan:
- A5 00 05 02 10 20 30 -> strobes addr 5,6,7 with data 10,20,30 on cycles +1 after each valid; frame_done with 3rd strobe.
- A5 00 BF 01 AA BB (TOTAL=192) -> writes addr 191=AA, then wraps to addr 0=BB; frame_done.
- A5 00 C8 01 11 22 (start 200 >= 192) -> frame_error after LEN byte, no strobes, the 2 payload bytes are consumed, busy drops after 22.
- Noise 00 FF 12 then A5 00 00 00 A5 -> no strobes for the noise, one strobe addr 0 data A5; back-to-back valids every cycle yield a strobe every cycle.
- Reset asserted after A5 00 03 with LEN 04 and 2 payload bytes sent -> state IDLE, no strobe, no frame_error; the next full frame writes correctly.
- With MATRIX_FRAME_TIMEOUT_EN and TIMEOUT_CYCLES=50: A5 00 then 60 idle cycles -> frame_error at cycle 50, busy=0; a byte arriving exactly on the timeout cycle is processed instead.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the LED matrix frame path: geometry constants,
// parser state encoding and the total-outputs helper.
package matrix_pkg;

  localparam int OUTPUTS_PER_BOARD = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_AH  = 3'd1,
    GET_AL  = 3'd2,
    GET_LEN = 3'd3,
    DATA    = 3'd4,
    DISCARD = 3'd5
  } state_t;

  // Number of LED value memory locations across the whole board chain.
  function automatic int total_outputs(input int boards, input int rows);
    return boards * OUTPUTS_PER_BOARD * rows;
  endfunction

endpackage

// File: rtl/matrix_frame_writer_if.sv
// Byte-in / pixel-write channel between the byte receiver, the frame writer
// and the matrix output stage.
interface matrix_frame_writer_if #(
  parameter int ADDR_W = 9
);
  // Byte channel: byte_in is consumed on every clk edge where byte_valid_in is
  // high; there is no ready, so the writer accepts a byte every cycle.
  // Write channel: write_strobe_out marks one valid address/data pair per
  // cycle; address_out/data_out hold their last values between strobes.
  logic [7:0]        byte_in;
  logic              byte_valid_in;
  logic [ADDR_W-1:0] address_out;
  logic [7:0]        data_out;
  logic              write_strobe_out;

  modport master (
    output byte_in, byte_valid_in,
    input  address_out, data_out, write_strobe_out
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output address_out, data_out, write_strobe_out
  );
endinterface

// File: rtl/matrix_frame_writer.sv
// Parses sync/address/length/payload frames into LED memory writes.
// Optional inter-byte timeout enabled by defining MATRIX_FRAME_TIMEOUT_EN.
module matrix_frame_writer
  import matrix_pkg::*;
#(
  parameter int         BOARDS         = 3,
  parameter int         ROWS           = 4,
  parameter int         ADDR_W         = 9,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_frame_writer_if.slave   bus,
  output logic                   frame_done,
  output logic                   frame_error,
  output logic                   busy,
  output state_t                 state_dbg
);

  localparam int TOTAL = total_outputs(BOARDS, ROWS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  if (TOTAL > (1 << ADDR_W)) begin : g_total_chk
    $error("TOTAL does not fit in ADDR_W");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state_q, state_d;
  logic [8:0]        start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [7:0]        data_q, data_d;
  logic              strobe_d, done_d, err_d;
  logic              strobe_q, done_q, err_q;

`ifdef MATRIX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    addr_out_d = addr_out_q;
    data_d     = data_q;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (bus.byte_valid_in) begin
      case (state_q)
        IDLE: begin
          if (bus.byte_in == SYNC_BYTE) state_d = GET_AH;
        end
        GET_AH: begin
          start_d[8] = bus.byte_in[0];
          state_d    = GET_AL;
        end
        GET_AL: begin
          start_d[7:0] = bus.byte_in;
          state_d      = GET_LEN;
        end
        GET_LEN: begin
          cnt_d  = bus.byte_in;
          addr_d = ADDR_W'(start_q);
          // Out-of-range start: payload is still swallowed so the stream stays framed.
          if ({23'd0, start_q} < TOTAL) begin
            state_d = DATA;
          end else begin
            state_d = DISCARD;
            err_d   = 1'b1;
          end
        end
        DATA: begin
          addr_out_d = addr_q;
          data_d     = bus.byte_in;
          strobe_d   = 1'b1;
          addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          if (cnt_q == 8'd0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        DISCARD: begin
          if (cnt_q == 8'd0) state_d = IDLE;
          else cnt_d = cnt_q - 8'd1;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef MATRIX_FRAME_TIMEOUT_EN
    // A byte arriving on the expiry cycle takes priority over the timeout.
    else if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
`endif
  end

`ifdef MATRIX_FRAME_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (bus.byte_valid_in || state_q == IDLE) tmo_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      addr_out_q <= '0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      addr_out_q <= addr_out_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.address_out      = addr_out_q;
  assign bus.data_out         = data_q;
  assign bus.write_strobe_out = strobe_q;
  assign frame_done           = done_q;
  assign frame_error          = err_q;
  assign busy                 = (state_q != IDLE);
  assign state_dbg            = state_q;

endmodule

// File: tb/tb_matrix_frame_writer.sv
// Directed bench for matrix_frame_writer: framing, wrap, range reject, noise,
// back-to-back bytes, mid-frame reset and (when enabled) the inter-byte timeout.
module tb_matrix_frame_writer;
  import matrix_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   frame_done, frame_error, busy;
  state_t state_dbg;
  int     total = 0;
  int     bad = 0;

  matrix_frame_writer_if #(.ADDR_W(9)) bus ();

  matrix_frame_writer #(
    .BOARDS(3), .ROWS(4), .ADDR_W(9), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .frame_done(frame_done), .frame_error(frame_error),
    .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns #1 after the edge that consumed it.
  task automatic drive(input logic [7:0] b);
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid_in = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic step(input string tag, input logic [7:0] b, input logic s,
                      input logic [8:0] a, input logic [7:0] d,
                      input logic dn, input logic er, input logic bz);
    drive(b);
    chk({tag, ".strobe"}, 32'(bus.write_strobe_out), 32'(s));
    if (s) begin
      chk({tag, ".addr"}, 32'(bus.address_out), 32'(a));
      chk({tag, ".data"}, 32'(bus.data_out), 32'(d));
    end
    chk({tag, ".done"}, 32'(frame_done), 32'(dn));
    chk({tag, ".err"}, 32'(frame_error), 32'(er));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
  endtask

  initial begin
    bus.byte_in       = 8'h00;
    bus.byte_valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.strobe", 32'(bus.write_strobe_out), 32'd0);
    chk("rst.addr", 32'(bus.address_out), 32'd0);
    chk("rst.data", 32'(bus.data_out), 32'd0);
    chk("rst.done", 32'(frame_done), 32'd0);
    chk("rst.err", 32'(frame_error), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    idle_cycle();

    // Basic 3-byte frame at address 5
    step("f1.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f1.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f1.al",   8'h05, 0, 0, 0, 0, 0, 1);
    step("f1.len",  8'h02, 0, 0, 0, 0, 0, 1);
    step("f1.d0",   8'h10, 1, 9'd5, 8'h10, 0, 0, 1);
    step("f1.d1",   8'h20, 1, 9'd6, 8'h20, 0, 0, 1);
    step("f1.d2",   8'h30, 1, 9'd7, 8'h30, 1, 0, 0);
    idle_cycle();
    chk("hold.strobe", 32'(bus.write_strobe_out), 32'd0);
    chk("hold.addr", 32'(bus.address_out), 32'd7);
    chk("hold.data", 32'(bus.data_out), 32'h30);
    chk("hold.done", 32'(frame_done), 32'd0);

    // Wrap from TOTAL-1 to 0
    step("f2.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f2.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f2.al",   8'hBF, 0, 0, 0, 0, 0, 1);
    step("f2.len",  8'h01, 0, 0, 0, 0, 0, 1);
    step("f2.d0",   8'hAA, 1, 9'd191, 8'hAA, 0, 0, 1);
    step("f2.d1",   8'hBB, 1, 9'd0, 8'hBB, 1, 0, 0);

    // Start 200 is out of range: error, payload discarded
    step("f3.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f3.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f3.al",   8'hC8, 0, 0, 0, 0, 0, 1);
    step("f3.len",  8'h01, 0, 0, 0, 0, 1, 1);
    step("f3.p0",   8'h11, 0, 0, 0, 0, 0, 1);
    step("f3.p1",   8'h22, 0, 0, 0, 0, 0, 0);

    // Start exactly TOTAL is rejected too
    step("f4.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f4.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f4.al",   8'hC0, 0, 0, 0, 0, 0, 1);
    step("f4.len",  8'h00, 0, 0, 0, 0, 1, 1);
    step("f4.p0",   8'h99, 0, 0, 0, 0, 0, 0);

    // Noise ignored, then SYNC value as payload
    step("n.0", 8'h00, 0, 0, 0, 0, 0, 0);
    step("n.1", 8'hFF, 0, 0, 0, 0, 0, 0);
    step("n.2", 8'h12, 0, 0, 0, 0, 0, 0);
    step("f5.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f5.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f5.al",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f5.len",  8'h00, 0, 0, 0, 0, 0, 1);
    step("f5.d0",   8'hA5, 1, 9'd0, 8'hA5, 1, 0, 0);

    // ADDR_H bits 7:1 ignored; back-to-back payload strobes every cycle
    step("f6.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f6.ah",   8'hFE, 0, 0, 0, 0, 0, 1);
    step("f6.al",   8'h10, 0, 0, 0, 0, 0, 1);
    step("f6.len",  8'h03, 0, 0, 0, 0, 0, 1);
    step("f6.d0",   8'h01, 1, 9'd16, 8'h01, 0, 0, 1);
    step("f6.d1",   8'h02, 1, 9'd17, 8'h02, 0, 0, 1);
    step("f6.d2",   8'h03, 1, 9'd18, 8'h03, 0, 0, 1);
    step("f6.d3",   8'h04, 1, 9'd19, 8'h04, 1, 0, 0);

    // Mid-frame reset with a valid byte present in the reset cycle
    step("f7.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f7.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f7.al",   8'h03, 0, 0, 0, 0, 0, 1);
    step("f7.len",  8'h04, 0, 0, 0, 0, 0, 1);
    step("f7.d0",   8'h51, 1, 9'd3, 8'h51, 0, 0, 1);
    step("f7.d1",   8'h52, 1, 9'd4, 8'h52, 0, 0, 1);
    rst = 1'b1;
    drive(8'h53);
    chk("mrst.strobe", 32'(bus.write_strobe_out), 32'd0);
    chk("mrst.err", 32'(frame_error), 32'd0);
    chk("mrst.done", 32'(frame_done), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    step("f8.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("f8.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    step("f8.al",   8'h08, 0, 0, 0, 0, 0, 1);
    step("f8.len",  8'h00, 0, 0, 0, 0, 0, 1);
    step("f8.d0",   8'h77, 1, 9'd8, 8'h77, 1, 0, 0);

    // Truncated frame: timeout after 50 idle cycles, or waits forever
    step("t1.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("t1.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i < 50; i++) begin
      idle_cycle();
      chk("t1.wait.err", 32'(frame_error), 32'd0);
      chk("t1.wait.busy", 32'(busy), 32'd1);
    end
    idle_cycle();
`ifdef MATRIX_FRAME_TIMEOUT_EN
    chk("t1.tmo.err", 32'(frame_error), 32'd1);
    chk("t1.tmo.busy", 32'(busy), 32'd0);
    idle_cycle();
    chk("t1.after.err", 32'(frame_error), 32'd0);

    // Byte arriving on the expiry cycle is processed instead
    step("t2.sync", 8'hA5, 0, 0, 0, 0, 0, 1);
    step("t2.ah",   8'h00, 0, 0, 0, 0, 0, 1);
    repeat (49) idle_cycle();
    step("t2.al",   8'h05, 0, 0, 0, 0, 0, 1);
    step("t2.len",  8'h00, 0, 0, 0, 0, 0, 1);
    step("t2.d0",   8'h42, 1, 9'd5, 8'h42, 1, 0, 0);
`else
    chk("t1.hold.err", 32'(frame_error), 32'd0);
    chk("t1.hold.busy", 32'(busy), 32'd1);
    repeat (20) idle_cycle();
    chk("t1.long.busy", 32'(busy), 32'd1);
    step("t1.al",   8'h05, 0, 0, 0, 0, 0, 1);
    step("t1.len",  8'h00, 0, 0, 0, 0, 0, 1);
    step("t1.d0",   8'h42, 1, 9'd5, 8'h42, 1, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
